// File: rtl/display_scheduler_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
package display_pkg;

    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SHOW   = 2'd1,
        PINNED = 2'd2
    } state_e;

    // Digit k stays lit once it or any higher nibble is non-zero.
    function automatic logic [DIGITS-1:0] lzb_mask(
        input logic [DIGITS*NIBBLE_W-1:0] n
    );
        logic [DIGITS-1:0] m;
        logic              seen;
        seen = 1'b0;
        m    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen = seen | (|n[k*NIBBLE_W +: NIBBLE_W]);
            m[k] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Source/control bundle between the value sources and the display scheduler.
// Master drives sources and controls; slave is the scheduler.
interface display_scheduler_if
    import display_pkg::*;
#(
    parameter int NUM_SRC = 4
);
    logic [16*NUM_SRC-1:0]         src_number;
    logic [NUM_SRC-1:0]            src_valid;
    logic                          next_btn;
    logic                          pin_req;
    logic [1:0]                    pin_sel;
    logic [DIGITS*NIBBLE_W-1:0]    number;
    logic [DIGITS-1:0]             dp;
    logic [DIGITS-1:0]             digit_mask;
    logic [1:0]                    cur_src;
    logic                          switched;

    modport master (
        output src_number, src_valid, next_btn, pin_req, pin_sel,
        input  number, dp, digit_mask, cur_src, switched
    );

    modport slave (
        input  src_number, src_valid, next_btn, pin_req, pin_sel,
        output number, dp, digit_mask, cur_src, switched
    );
endinterface

// File: rtl/display_scheduler_rr_pick.sv
// Round-robin search: first valid index after cur_i, wrapping, ending at cur_i.
module rr_pick
    import display_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] valid_i,
    input  logic [1:0]         cur_i,
    output logic [1:0]         nxt_o,
    output logic               any_o
);
    logic [7:0] v8;
    logic [2:0] idx;

    assign v8    = 8'(valid_i);
    assign any_o = |valid_i;

    // Walk farthest offset first so the nearest valid index wins.
    always_comb begin
        nxt_o = cur_i;
        idx   = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = 3'(cur_i) + 3'(i);
            if (idx >= 3'(NUM_SRC)) idx = idx - 3'(NUM_SRC);
            if (v8[idx]) nxt_o = idx[1:0];
        end
    end
endmodule

// File: rtl/display_scheduler.sv
// Shares one 4-digit display between up to four sources with dwell/pin control.
// Define DISPLAY_LZB_EN to blank leading zero digits.
module display_scheduler
    import display_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DWELL   = 50_000_000,
    parameter int CNT_W   = 26
) (
    input logic                clk,
    input logic                rst,
    display_scheduler_if.slave bus
);
    state_e             state_q, state_d;
    logic [1:0]         cur_q, cur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        number_q;
    logic [DIGITS-1:0]  dp_q;
    logic               show_q;
    logic               switched_q;

    logic [3:0]         v4;
    logic [63:0]        num_pad;
    logic [1:0]         rr_nxt, low_idx, pin_idx;
    logic               any_v, low_any, advance;
    logic [DIGITS-1:0]  mask_full;

    assign v4      = 4'(bus.src_valid);
    assign num_pad = 64'(bus.src_number);
    assign pin_idx = ({1'b0, bus.pin_sel} >= 3'(NUM_SRC))
                   ? 2'd0 : bus.pin_sel;
    assign advance = (cnt_q == CNT_W'(DWELL - 1))
                   | bus.next_btn
                   | ~v4[cur_q];

    rr_pick #(.NUM_SRC(NUM_SRC)) u_rr (
        .valid_i (bus.src_valid),
        .cur_i   (cur_q),
        .nxt_o   (rr_nxt),
        .any_o   (any_v)
    );

    // Searching from the last index yields the lowest valid source.
    rr_pick #(.NUM_SRC(NUM_SRC)) u_low (
        .valid_i (bus.src_valid),
        .cur_i   (2'(NUM_SRC - 1)),
        .nxt_o   (low_idx),
        .any_o   (low_any)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BLANK: begin
                cnt_d = '0;
                if (bus.pin_req) begin
                    state_d = PINNED;
                    cur_d   = pin_idx;
                end else if (low_any) begin
                    state_d = SHOW;
                    cur_d   = low_idx;
                end
            end
            SHOW: begin
                if (bus.pin_req) begin
                    state_d = PINNED;
                    cur_d   = pin_idx;
                    cnt_d   = '0;
                end else if (!any_v) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end else if (advance) begin
                    cur_d = rr_nxt;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PINNED: begin
                cnt_d = '0;
                if (bus.pin_req) cur_d = pin_idx;
                else             state_d = SHOW;
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BLANK;
            cur_q      <= '0;
            cnt_q      <= '0;
            number_q   <= '0;
            dp_q       <= '0;
            show_q     <= 1'b0;
            switched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            show_q     <= (state_q != BLANK);
            switched_q <= (cur_d != cur_q);
            if (state_q == BLANK) begin
                number_q <= '0;
                dp_q     <= '0;
            end else begin
                number_q <= num_pad[{cur_q, 4'b0000} +: 16];
                dp_q     <= 4'b0001 << cur_q;
            end
        end
    end

`ifdef DISPLAY_LZB_EN
    assign mask_full = lzb_mask(number_q);
`else
    assign mask_full = '1;
`endif

    assign bus.number     = number_q;
    assign bus.dp         = dp_q;
    assign bus.digit_mask = show_q ? mask_full : '0;
    assign bus.cur_src    = cur_q;
    assign bus.switched   = switched_q;
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequencer that shares the 4-digit seven-segment display between up to four 16-bit value sources, such as the SAP-1 bus, PC, A register and output register. It rotates through the valid sources on a dwell timer or on a manual advance pulse, and supports pinning one source. It drives the `number`, `dp` and `digit_mask` inputs of the quadruple display driver, marking the active source index on the decimal points.

## Interface
- `NUM_SRC`, 4: number of sources, legal 2..4; source index is always 2 bits.
- `DWELL`, 50_000_000: clk cycles each source is shown before auto-advance; ≥2.
- `CNT_W`, 26: dwell counter width; must hold DWELL-1.

Ports:
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `src_number`  in  16*NUM_SRC: source i occupies bits [16i+15:16i].
- `src_valid`  in  NUM_SRC: source i currently has something to show.
- `next_btn`  in  1: single-cycle advance pulse, already debounced and synchronous.
- `pin_req`  in  1: level; while high, hold the display on `pin_sel`.
- `pin_sel`  in  2: source to pin; values ≥ NUM_SRC are treated as 0.
- `number`  out  16: value to display, registered.
- `dp`  out  4: one-hot of `cur_src` (dp[cur_src]=1); 0000 in BLANK.
- `digit_mask`  out  4: digit enables for the display driver.
- `cur_src`  out  2: source being shown.
- `switched`  out  1: one-cycle pulse when `cur_src` changes.

## Operation
- States: BLANK, SHOW, PINNED.
- Round-robin pick: the next valid source is found by searching indices `cur_src+1`, `cur_src+2`, … with wrap modulo NUM_SRC, ending at `cur_src` itself.
- BLANK:
  - `digit_mask`=0000, `dp`=0000, `number`=0000.
  - If any `src_valid` is set, go to SHOW on the lowest-index valid source, counter=0.
  - If `pin_req`, go to PINNED.
- SHOW advances to the round-robin pick and clears the counter when any of these occur:
  - counter==DWELL-1;
  - `next_btn`;
  - `src_valid[cur_src]` drops.
- SHOW exits and special cases:
  - If no source is valid, go to BLANK.
  - If the only valid source is the current one, `cur_src` stays unchanged, the counter restarts and `switched` stays low.
  - `pin_req` high goes to PINNED with `cur_src`=`pin_sel`.
- PINNED:
  - Shows `pin_sel`, ignoring `src_valid` and `next_btn`; the counter is held at 0.
  - A `pin_sel` change while pinned updates `cur_src` and pulses `switched`.
  - When `pin_req` falls, go to SHOW on the same source with counter=0. The next SHOW cycle then applies the normal rules, so an invalid source is left at once.
- Event priority, highest first: `pin_req` > loss of all valid sources > `next_btn` / dwell expiry / current-source invalid.
  - Simultaneous advance causes produce exactly one advance.
- `number` follows `src_number[cur_src]` continuously, with one register stage, so source values update live while shown.
- `digit_mask` is 1111 in SHOW and PINNED unless leading-zero blanking applies (see Configuration).

## Timing
- Reset values: BLANK state, `cur_src`=0, counter=0, `number`=0000, `dp`=0000, `digit_mask`=0000, `switched`=0.
- Reset is honoured mid-dwell and mid-pin.
- State, `cur_src` and counter update on the clock edge following the triggering input.
- `number`, `dp` and `digit_mask` lag `cur_src` by 1 cycle. `switched` is asserted in the same cycle as the new `cur_src`.
- With no event, auto-advance occurs every DWELL cycles.
- `next_btn` takes effect in 1 cycle. Back-to-back pulses advance once per pulse.

## Configuration
- `DISPLAY_LZB_EN` defined: leading-zero blanking.
  - `digit_mask` bit k is cleared when nibble k and all higher nibbles of the registered `number` are zero.
  - Bit 0 is always set, so 0x0000 gives 0001 and 0x00A3 gives 0011.
  - The mask is computed from the same registered value, adding no extra latency.
- Not defined: `digit_mask` is 1111 in SHOW and PINNED.

## Structure
- `display_pkg` holds:
  - `DIGITS`=4 and `NIBBLE_W`=4;
  - state encoding: BLANK=2'd0, SHOW=2'd1, PINNED=2'd2.
- One sub-module, `rr_pick`: combinational; takes valid vector, current index and NUM_SRC; returns next index and `any_valid`.

## Test plan
- Use DWELL=4, NUM_SRC=4 and sources 0x1111/0x2222/0x3333/0x4444 with all valid → `cur_src` sequence 0,1,2,3,0 changing every 4 cycles, `switched` pulsing at each change, `dp` 0001→0010→0100→1000.
- Set `src_valid`=0101 and pulse `next_btn` three times → `cur_src` 0→2→0→2; drop valid[2] while shown → `cur_src`=0 next cycle; set valid=0000 → BLANK, mask 0000.
- Raise `pin_req` with `pin_sel`=3 while valid[3]=0 → `number`=0x4444 held past 3×DWELL, `next_btn` ignored; release → immediate advance to a valid source.
- Apply `pin_req`, `next_btn` and dwell expiry in the same cycle → PINNED, no extra advance.
- Assert reset mid-dwell on source 2 → all outputs at reset values immediately; after release BLANK→SHOW on lowest valid source.
- With `DISPLAY_LZB_EN`: sources 0x0000, 0x00A3 and 0x0F00 → masks 0001, 0011 and 0111; without the macro → 1111 for each.
